// File: rtl/rcv_fifo_if.sv
// ----------------------------------------------------------------------------
// rcv_fifo_if : receive-side bus between serial receiver/register file and rcv_fifo
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface rcv_fifo_if #(
   parameter int DEPTH_LOG2 = 4
);
   logic                  sr_full;
   logic [7:0]            parallel_in;
   logic                  rd;
   logic                  ovr_clr;
   logic                  ready;
   logic [7:0]            data_out;
   logic [DEPTH_LOG2:0]   level;
   logic                  overrun;

   modport master (
      output sr_full, parallel_in, rd, ovr_clr,
      input  ready, data_out, level, overrun
   );

   modport slave (
      input  sr_full, parallel_in, rd, ovr_clr,
      output ready, data_out, level, overrun
   );
endinterface

`default_nettype wire

// File: rtl/rcv_fifo.sv
// ----------------------------------------------------------------------------
// rcv_fifo : first-word-fall-through byte queue behind the serial receiver
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rcv_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   rcv_fifo_if.slave bus
);
   localparam int                  DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2:0]   level_q;
   logic [DEPTH_LOG2:0]   level_nxt;
   logic                  ready_q;
   logic                  overrun_q;
   logic                  sf_q;
   logic                  wr_ev;
   logic                  rd_ev;
   logic                  full;
   logic                  wr_acc;
   logic                  wr_drop;

   // A read on a full queue frees the slot the coincident write needs.
   always_comb begin
      wr_ev     = bus.sr_full & ~sf_q;
      rd_ev     = bus.rd & (level_q != '0);
      full      = (level_q == FULL_LEVEL);
      wr_acc    = wr_ev & (~full | rd_ev);
      wr_drop   = wr_ev & full & ~rd_ev;
      level_nxt = level_q;
      if (wr_acc && !rd_ev) begin
         level_nxt = level_q + LEVEL_ONE;
      end else if (rd_ev && !wr_acc) begin
         level_nxt = level_q - LEVEL_ONE;
      end
   end

   // Edge detector resets high so a strobe held across reset release is ignored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sf_q      <= 1'b1;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         level_q   <= '0;
         ready_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         sf_q    <= bus.sr_full;
         level_q <= level_nxt;
         ready_q <= (level_nxt != '0);
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_ev) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (wr_drop) begin
            overrun_q <= 1'b1;
         end else if (bus.ovr_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && wr_acc) begin
         mem[wr_ptr] <= bus.parallel_in;
      end
   end

   assign bus.ready    = ready_q;
   assign bus.level    = level_q;
   assign bus.overrun  = overrun_q;
   assign bus.data_out = (level_q != '0) ? mem[rd_ptr] : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_rcv_fifo.sv
// ----------------------------------------------------------------------------
// tb_rcv_fifo : directed and randomized checks of rcv_fifo against a queue model
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rcv_fifo;
   localparam int DEPTH_LOG2 = 4;
   localparam int DEPTH      = 1 << DEPTH_LOG2;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   rcv_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

   rcv_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a plain queue plus a sticky flag and the previous strobe.
   logic [7:0] q[$];
   bit         m_ovr;
   bit         m_prev;
   int         n_accepted;

   task automatic model_step();
      bit we;
      bit re;
      if (!rst_n) begin
         q.delete();
         m_ovr  = 1'b0;
         m_prev = 1'b1;
         return;
      end
      we = bus.sr_full && !m_prev;
      re = bus.rd && (q.size() > 0);
      if (re) void'(q.pop_front());
      if (we && q.size() >= DEPTH) begin
         m_ovr = 1'b1;
      end else begin
         if (we) begin
            q.push_back(bus.parallel_in);
            n_accepted++;
         end
         if (bus.ovr_clr) m_ovr = 1'b0;
      end
      m_prev = bus.sr_full;
   endtask

   function automatic logic [7:0] exp_data();
      return (q.size() > 0) ? q[0] : 8'h00;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic pulse(input logic [7:0] b);
      bus.sr_full = 1'b1; bus.parallel_in = b; tick();
      bus.sr_full = 1'b0; tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; bus.sr_full = 1'b1; bus.parallel_in = 8'hEE;
      tick(); tick();
      n_total++; if (bus.level !== 5'd0)   $display("FAIL reset_level got %0d want 0", bus.level);   else n_pass++;
      n_total++; if (bus.ready !== 1'b0)   $display("FAIL reset_ready got %b want 0", bus.ready);    else n_pass++;
      n_total++; if (bus.overrun !== 1'b0) $display("FAIL reset_ovr got %b want 0", bus.overrun);  else n_pass++;
      n_total++; if (bus.data_out !== 8'h00) $display("FAIL reset_data got %h want 00", bus.data_out); else n_pass++;
      rst_n = 1'b1; tick();
      n_total++; if (bus.level !== 5'd0) $display("FAIL held_strobe_at_release got level %0d want 0", bus.level); else n_pass++;
      bus.sr_full = 1'b0; tick();
   endtask

   task automatic test_single();
      bus.sr_full = 1'b1; bus.parallel_in = 8'h41; tick();
      bus.sr_full = 1'b0;
      n_total++; if (bus.ready !== 1'b1) $display("FAIL single_ready got %b want 1", bus.ready); else n_pass++;
      n_total++; if (bus.level !== 5'd1) $display("FAIL single_level got %0d want 1", bus.level); else n_pass++;
      n_total++; if (bus.data_out !== 8'h41) $display("FAIL single_data got %h want 41", bus.data_out); else n_pass++;
      bus.rd = 1'b1; tick(); bus.rd = 1'b0;
      n_total++; if (bus.ready !== 1'b0 || bus.level !== 5'd0 || bus.data_out !== 8'h00)
         $display("FAIL single_pop got ready=%b level=%0d data=%h want 0/0/00", bus.ready, bus.level, bus.data_out);
      else n_pass++;
   endtask

   task automatic test_held();
      bus.sr_full = 1'b1; bus.parallel_in = 8'h55;
      repeat (5) tick();
      bus.sr_full = 1'b0; tick();
      n_total++; if (bus.level !== 5'd1 || bus.data_out !== 8'h55)
         $display("FAIL held_one_write got level=%0d data=%h want 1/55", bus.level, bus.data_out);
      else n_pass++;
      bus.rd = 1'b1; tick(); bus.rd = 1'b0;
   endtask

   task automatic test_fill_overrun();
      for (int i = 0; i < 16; i++) pulse(8'(i));
      pulse(8'hAA);
      n_total++; if (bus.level !== 5'd16) $display("FAIL fill_level got %0d want 16", bus.level); else n_pass++;
      n_total++; if (bus.overrun !== 1'b1) $display("FAIL fill_overrun got %b want 1", bus.overrun); else n_pass++;
      for (int i = 0; i < 16; i++) begin
         n_total++; if (bus.data_out !== 8'(i)) $display("FAIL fill_order[%0d] got %h want %h", i, bus.data_out, 8'(i)); else n_pass++;
         bus.rd = 1'b1; tick();
      end
      bus.rd = 1'b0;
      n_total++; if (bus.level !== 5'd0 || bus.data_out !== 8'h00)
         $display("FAIL fill_drained got level=%0d data=%h want 0/00", bus.level, bus.data_out);
      else n_pass++;
      bus.ovr_clr = 1'b1; tick(); bus.ovr_clr = 1'b0;
      n_total++; if (bus.overrun !== 1'b0) $display("FAIL ovr_clr got %b want 0", bus.overrun); else n_pass++;
   endtask

   task automatic test_full_simul();
      for (int i = 0; i < 16; i++) pulse(8'h10 + 8'(i));
      bus.sr_full = 1'b1; bus.parallel_in = 8'h77; bus.rd = 1'b1; tick();
      bus.sr_full = 1'b0; bus.rd = 1'b0;
      n_total++; if (bus.level !== 5'd16 || bus.overrun !== 1'b0)
         $display("FAIL full_simul got level=%0d ovr=%b want 16/0", bus.level, bus.overrun);
      else n_pass++;
      for (int i = 0; i < 16; i++) begin
         logic [7:0] want;
         want = (i < 15) ? 8'h11 + 8'(i) : 8'h77;
         n_total++; if (bus.data_out !== want) $display("FAIL full_simul_order[%0d] got %h want %h", i, bus.data_out, want); else n_pass++;
         bus.rd = 1'b1; tick();
      end
      bus.rd = 1'b0;
      // Overrun set/clear priority.
      for (int i = 0; i < 16; i++) pulse(8'h20 + 8'(i));
      pulse(8'hC1);
      bus.sr_full = 1'b1; bus.parallel_in = 8'hC2; bus.ovr_clr = 1'b1; tick();
      bus.sr_full = 1'b0; bus.ovr_clr = 1'b0;
      n_total++; if (bus.overrun !== 1'b1) $display("FAIL ovr_set_wins got %b want 1", bus.overrun); else n_pass++;
      bus.ovr_clr = 1'b1; tick(); bus.ovr_clr = 1'b0;
      n_total++; if (bus.overrun !== 1'b0) $display("FAIL ovr_clear_alone got %b want 0", bus.overrun); else n_pass++;
      bus.rd = 1'b1; repeat (16) tick(); bus.rd = 1'b0;
      n_total++; if (bus.level !== 5'd0) $display("FAIL ovr_drain got level %0d want 0", bus.level); else n_pass++;
   endtask

   task automatic test_empty_simul();
      bus.sr_full = 1'b1; bus.parallel_in = 8'h33; bus.rd = 1'b1; tick();
      bus.sr_full = 1'b0; bus.rd = 1'b0;
      n_total++; if (bus.level !== 5'd1 || bus.data_out !== 8'h33)
         $display("FAIL empty_simul got level=%0d data=%h want 1/33", bus.level, bus.data_out);
      else n_pass++;
      bus.rd = 1'b1; tick(); tick(); bus.rd = 1'b0;
      n_total++; if (bus.level !== 5'd0 || bus.ready !== 1'b0)
         $display("FAIL rd_on_empty got level=%0d ready=%b want 0/0", bus.level, bus.ready);
      else n_pass++;
   endtask

   task automatic test_random_wrap();
      int cyc;
      int errs;
      n_accepted = 0;
      cyc = 0;
      errs = 0;
      while (n_accepted < 40 && cyc < 2000) begin
         bus.sr_full     = 1'($urandom_range(0, 1));
         bus.parallel_in = 8'($urandom);
         bus.rd          = ($urandom_range(0, 2) == 0);
         tick();
         cyc++;
         if (bus.level !== 5'(q.size()) || bus.data_out !== exp_data() ||
             bus.ready !== (q.size() > 0) || bus.overrun !== m_ovr) begin
            if (errs < 5)
               $display("FAIL random[%0d] got level=%0d data=%h ready=%b ovr=%b want %0d/%h/%b/%b",
                        cyc, bus.level, bus.data_out, bus.ready, bus.overrun,
                        q.size(), exp_data(), q.size() > 0, m_ovr);
            errs++;
         end
      end
      n_total++; if (errs != 0) $display("FAIL random_stream got %0d bad cycles want 0", errs); else n_pass++;
      n_total++; if (n_accepted < 40) $display("FAIL random_budget got %0d writes want 40", n_accepted); else n_pass++;
      bus.sr_full = 1'b0; bus.rd = 1'b0; tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 17; i++) pulse(8'($urandom));
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      n_total++; if (bus.level !== 5'd0 || bus.ready !== 1'b0 || bus.overrun !== 1'b0)
         $display("FAIL reset_mid got level=%0d ready=%b ovr=%b want 0/0/0", bus.level, bus.ready, bus.overrun);
      else n_pass++;
      tick();
      n_total++; if (bus.data_out !== 8'h00) $display("FAIL reset_mid_data got %h want 00", bus.data_out); else n_pass++;
   endtask

   initial begin
      n_pass = 0; n_total = 0; n_accepted = 0;
      m_ovr = 1'b0; m_prev = 1'b1;
      rst_n = 1'b0;
      bus.sr_full = 1'b0; bus.parallel_in = 8'h00; bus.rd = 1'b0; bus.ovr_clr = 1'b0;
      #2;
      test_reset();
      test_single();
      test_held();
      test_fill_overrun();
      test_full_simul();
      test_empty_simul();
      test_random_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rcv_fifo.md
Name: rcv_fifo

Overview:
- Receive buffer directly downstream of the serial line receiver.
- Captures each assembled byte when the receiver's `sr_full` strobe rises and queues it in a small first-in-first-out store.
- Presents the oldest byte to the I/O register interface with ready, level and sticky-overrun status, so the processor can tolerate bursts of back-to-back characters without losing data.

Parameters:
- DEPTH_LOG2, 4, log2 of the number of entries (default 16 entries; legal range 1..8).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- sr_full  in  1  byte-complete strobe from the receiver.
- parallel_in  in  8  received byte from the receiver; valid while sr_full is high.
- rd  in  1  read strobe from the register interface; pops the head entry.
- ovr_clr  in  1  clears the overrun flag.
- ready  out  1  high when at least one byte is queued.
- data_out  out  8  head (oldest) byte.
- level  out  DEPTH_LOG2+1  number of queued bytes, 0..2^DEPTH_LOG2.
- overrun  out  1  sticky; set when a byte is dropped because the buffer is full.

Behaviour:
- Reset (rst_n low at a clock edge):
  - Read pointer, write pointer and level go to 0.
  - ready=0, overrun=0, data_out=8'h00.
  - The sr_full edge-detect register is loaded with 1. A strobe already high when reset releases is therefore not captured.
  - Storage contents are not cleared.
  - Reset mid-operation discards all queued bytes.
- Capture (write event):
  - Registered copy sf_q of sr_full.
  - Write event in cycle N = sr_full high and sf_q low, i.e. a rising edge.
  - A strobe held high for many cycles produces exactly one write.
  - parallel_in is sampled in the same cycle as the write event.
- Write accepted (not full, or full with a simultaneous accepted read):
  - Byte stored at the write pointer.
  - Write pointer incremented modulo 2^DEPTH_LOG2.
- Write when full and no read in the same cycle:
  - Byte dropped; pointers and level unchanged.
  - overrun set to 1 at the next edge.
- Read event:
  - rd high and level != 0. The read pointer increments modulo depth.
  - rd while empty is ignored: no pointer change, no error flag.
  - rd is level-sensitive; each cycle rd is high with level != 0 pops one byte.
- Level update:
  - Increments on write-only, decrements on read-only.
  - Unchanged on simultaneous write+read, or on neither.
  - Never exceeds 2^DEPTH_LOG2, never goes below 0.
- Empty corner case: simultaneous write and rd while empty → the write is accepted, the read is ignored, and level becomes 1.
- Full corner case: simultaneous write and rd while full → both are accepted, level stays full, no overrun.
- Outputs:
  - ready = (level != 0), registered together with level.
  - data_out = storage[read pointer] when level != 0, else 8'h00.
  - First-word-fall-through: a byte written at edge N is visible on data_out/ready after edge N, i.e. in cycle N+1. Latency from sr_full rise to ready is 1 clock.
- Overrun flag:
  - Cleared by ovr_clr high at an edge.
  - If ovr_clr and a dropped write coincide, set wins and overrun stays 1.
  - overrun does not affect normal reads or writes.
- Pointer wrap: pointers are DEPTH_LOG2 bits wide and wrap silently; full/empty are distinguished solely by level.

Test Plan:
- Reset, then one sr_full pulse with parallel_in=8'h41 → next cycle ready=1, level=1, data_out=8'h41; pulse rd one cycle → ready=0, level=0, data_out=8'h00.
- sr_full held high 5 cycles with 8'h55 → exactly one entry, level=1.
- 16 pulses with bytes 8'h00..8'h0F, then a 17th pulse with 8'hAA → level=16, overrun=1; reading 16 times returns 8'h00..8'h0F in order, and 8'hAA never appears.
- Full buffer, sr_full rise with 8'h77 and rd in the same cycle → level stays 16, overrun stays 0, 8'h77 is read last; ovr_clr coincident with a dropped write → overrun remains 1, and a later ovr_clr alone → 0.
- Empty buffer, sr_full rise with 8'h33 and rd in the same cycle → level=1, data_out=8'h33; rd on empty → level stays 0.
- 40 interleaved writes and reads (pointer wrap past 16 twice) → data order preserved; rst_n low mid-stream → level=0, ready=0, overrun=0 on the next cycle.
